// File: rtl/calendar_counter.sv
// BCD calendar (year/month/day/weekday) advanced by day_tick and stepped back by day_dec.
// Loads are validated before being accepted; 2-digit years keep the century fixed.
module calendar_counter #(
    parameter int          YEAR_DIGITS = 4,
    parameter logic [7:0]  CENTURY     = 8'h20,
    parameter logic [31:0] RESET_DATE  = 32'h2019_0101,
    parameter logic [2:0]  RESET_WDAY  = 3'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        day_tick,
    input  logic        day_dec,
    input  logic        load,
    input  logic [31:0] set_date,
    input  logic [2:0]  set_wday,
    output logic [31:0] date_out,
    output logic [2:0]  wday_out,
    output logic        leap,
    output logic        month_wrap,
    output logic        year_wrap,
    output logic        load_err
);

    localparam logic        TWO_DIGIT   = (YEAR_DIGITS == 2);
    localparam logic [15:0] RESET_YEAR  = TWO_DIGIT ? {CENTURY, RESET_DATE[23:16]}
                                                    : RESET_DATE[31:16];
    localparam logic [7:0]  RESET_MONTH = RESET_DATE[15:8];
    localparam logic [7:0]  RESET_DAY   = RESET_DATE[7:0];

    function automatic logic div4(input logic [7:0] pair);
        logic t_even;
        logic o_ok_even;
        logic o_ok_odd;
        t_even    = (pair[7:4] == 4'd0) || (pair[7:4] == 4'd2) || (pair[7:4] == 4'd4) ||
                    (pair[7:4] == 4'd6) || (pair[7:4] == 4'd8);
        o_ok_even = (pair[3:0] == 4'd0) || (pair[3:0] == 4'd4) || (pair[3:0] == 4'd8);
        o_ok_odd  = (pair[3:0] == 4'd2) || (pair[3:0] == 4'd6);
        if (t_even) begin
            div4 = o_ok_even;
        end else begin
            div4 = o_ok_odd;
        end
    endfunction

    // A year ending in 00 falls back to the century pair (the 400-year rule in BCD form).
    function automatic logic is_leap(input logic [15:0] year);
        if (year[7:0] == 8'h00) begin
            is_leap = div4(year[15:8]);
        end else begin
            is_leap = div4(year[7:0]);
        end
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic lp);
        case (month)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: days_in_month = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      days_in_month = 8'h30;
            8'h02:   days_in_month = lp ? 8'h29 : 8'h28;
            default: days_in_month = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc8(input logic [7:0] pair);
        if (pair[3:0] == 4'd9) begin
            if (pair[7:4] == 4'd9) begin
                bcd_inc8 = 8'h00;
            end else begin
                bcd_inc8 = {pair[7:4] + 4'd1, 4'd0};
            end
        end else begin
            bcd_inc8 = {pair[7:4], pair[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_dec8(input logic [7:0] pair);
        if (pair[3:0] == 4'd0) begin
            if (pair[7:4] == 4'd0) begin
                bcd_dec8 = 8'h99;
            end else begin
                bcd_dec8 = {pair[7:4] - 4'd1, 4'd9};
            end
        end else begin
            bcd_dec8 = {pair[7:4], pair[3:0] - 4'd1};
        end
    endfunction

    function automatic logic [15:0] year_up(input logic [15:0] year);
        logic [7:0] hi;
        if (!TWO_DIGIT && (year[7:0] == 8'h99)) begin
            hi = bcd_inc8(year[15:8]);
        end else begin
            hi = year[15:8];
        end
        year_up = {hi, bcd_inc8(year[7:0])};
    endfunction

    function automatic logic [15:0] year_down(input logic [15:0] year);
        logic [7:0] hi;
        if (!TWO_DIGIT && (year[7:0] == 8'h00)) begin
            hi = bcd_dec8(year[15:8]);
        end else begin
            hi = year[15:8];
        end
        year_down = {hi, bcd_dec8(year[7:0])};
    endfunction

    function automatic logic nib_ok16(input logic [15:0] v);
        nib_ok16 = (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
                   (v[7:4]   <= 4'd9) && (v[3:0]  <= 4'd9);
    endfunction

    logic [15:0] year_r;
    logic [7:0]  month_r;
    logic [7:0]  day_r;
    logic [2:0]  wday_r;
    logic        month_wrap_r;
    logic        year_wrap_r;
    logic        load_err_r;

    logic [15:0] year_n_s;
    logic [7:0]  month_n_s;
    logic [7:0]  day_n_s;
    logic [2:0]  wday_n_s;
    logic        month_wrap_n_s;
    logic        year_wrap_n_s;
    logic        load_err_n_s;

    logic [15:0] set_year_s;
    logic [7:0]  set_month_s;
    logic [7:0]  set_day_s;
    logic        set_valid_s;
    logic [7:0]  cur_dim_s;
    logic [15:0] dec_year_s;
    logic [7:0]  dec_month_s;
    logic [7:0]  dec_dim_s;

    // Load decode and validation against the month length of the year being loaded.
    always_comb begin
        set_year_s  = TWO_DIGIT ? {CENTURY, set_date[23:16]} : set_date[31:16];
        set_month_s = set_date[15:8];
        set_day_s   = set_date[7:0];
        set_valid_s = nib_ok16(set_year_s) && nib_ok16({set_month_s, set_day_s}) &&
                      (set_month_s >= 8'h01) && (set_month_s <= 8'h12) &&
                      (set_day_s >= 8'h01) &&
                      (set_day_s <= days_in_month(set_month_s, is_leap(set_year_s))) &&
                      (set_wday <= 3'd6);
    end

    // Target month/year when stepping back across a month boundary.
    always_comb begin
        cur_dim_s = days_in_month(month_r, is_leap(year_r));
        if (month_r == 8'h01) begin
            dec_month_s = 8'h12;
            dec_year_s  = year_down(year_r);
        end else begin
            dec_month_s = bcd_dec8(month_r);
            dec_year_s  = year_r;
        end
        dec_dim_s = days_in_month(dec_month_s, is_leap(dec_year_s));
    end

    // Next-state: load wins, otherwise exactly one of tick/dec moves the date.
    always_comb begin
        year_n_s       = year_r;
        month_n_s      = month_r;
        day_n_s        = day_r;
        wday_n_s       = wday_r;
        month_wrap_n_s = 1'b0;
        year_wrap_n_s  = 1'b0;
        load_err_n_s   = load_err_r;
        if (load) begin
            if (set_valid_s) begin
                year_n_s     = set_year_s;
                month_n_s    = set_month_s;
                day_n_s      = set_day_s;
                wday_n_s     = set_wday;
                load_err_n_s = 1'b0;
            end else begin
                load_err_n_s = 1'b1;
            end
        end else if (day_tick && !day_dec) begin
            wday_n_s = (wday_r == 3'd6) ? 3'd0 : wday_r + 3'd1;
            if (day_r < cur_dim_s) begin
                day_n_s = bcd_inc8(day_r);
            end else begin
                day_n_s        = 8'h01;
                month_wrap_n_s = 1'b1;
                if (month_r == 8'h12) begin
                    month_n_s     = 8'h01;
                    year_n_s      = year_up(year_r);
                    year_wrap_n_s = 1'b1;
                end else begin
                    month_n_s = bcd_inc8(month_r);
                end
            end
        end else if (day_dec && !day_tick) begin
            wday_n_s = (wday_r == 3'd0) ? 3'd6 : wday_r - 3'd1;
            if (day_r > 8'h01) begin
                day_n_s = bcd_dec8(day_r);
            end else begin
                month_wrap_n_s = 1'b1;
                year_wrap_n_s  = (month_r == 8'h01);
                month_n_s      = dec_month_s;
                year_n_s       = dec_year_s;
                day_n_s        = dec_dim_s;
            end
        end else begin
            year_n_s = year_r;
        end
    end

    // Calendar state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            year_r       <= RESET_YEAR;
            month_r      <= RESET_MONTH;
            day_r        <= RESET_DAY;
            wday_r       <= RESET_WDAY;
            month_wrap_r <= 1'b0;
            year_wrap_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            year_r       <= year_n_s;
            month_r      <= month_n_s;
            day_r        <= day_n_s;
            wday_r       <= wday_n_s;
            month_wrap_r <= month_wrap_n_s;
            year_wrap_r  <= year_wrap_n_s;
            load_err_r   <= load_err_n_s;
        end
    end

    assign date_out   = {year_r, month_r, day_r};
    assign wday_out   = wday_r;
    assign leap       = is_leap(year_r);
    assign month_wrap = month_wrap_r;
    assign year_wrap  = year_wrap_r;
    assign load_err   = load_err_r;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: each step queues its expected outcome,
// which is popped and compared once the DUT has registered the step.
module tb_calendar_counter;

    logic        clk;
    logic        rst_n;
    logic        day_tick;
    logic        day_dec;
    logic        load;
    logic [31:0] set_date;
    logic [2:0]  set_wday;
    logic [31:0] date_out;
    logic [2:0]  wday_out;
    logic        leap;
    logic        month_wrap;
    logic        year_wrap;
    logic        load_err;

    typedef struct {
        logic [31:0] date;
        logic [2:0]  wday;
        logic        mw;
        logic        yw;
        logic        err;
        logic        lp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    localparam int OP_IDLE = 0, OP_LOAD = 1, OP_TICK = 2, OP_DEC = 3, OP_BOTH = 4, OP_LDTK = 5;

    calendar_counter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .day_tick   (day_tick),
        .day_dec    (day_dec),
        .load       (load),
        .set_date   (set_date),
        .set_wday   (set_wday),
        .date_out   (date_out),
        .wday_out   (wday_out),
        .leap       (leap),
        .month_wrap (month_wrap),
        .year_wrap  (year_wrap),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, date_out);
        end else begin
            n_checks--;
            e = exp_q.pop_front();
            check({tag, ".date"}, date_out, e.date);
            check({tag, ".wday"}, {29'd0, wday_out}, {29'd0, e.wday});
            check({tag, ".mw"},   {31'd0, month_wrap}, {31'd0, e.mw});
            check({tag, ".yw"},   {31'd0, year_wrap}, {31'd0, e.yw});
            check({tag, ".err"},  {31'd0, load_err}, {31'd0, e.err});
            check({tag, ".leap"}, {31'd0, leap}, {31'd0, e.lp});
        end
    endtask

    // Called at a negedge: drive one cycle of stimulus, queue the expectation, compare one cycle later.
    task automatic step(input string tag, input int op, input logic [31:0] sd, input logic [2:0] sw,
                        input logic [31:0] ed, input logic [2:0] ew, input logic emw,
                        input logic eyw, input logic eerr, input logic elp);
        exp_t e;
        load     = (op == OP_LOAD) || (op == OP_LDTK);
        day_tick = (op == OP_TICK) || (op == OP_BOTH) || (op == OP_LDTK);
        day_dec  = (op == OP_DEC)  || (op == OP_BOTH);
        set_date = sd;
        set_wday = sw;
        e.date = ed; e.wday = ew; e.mw = emw; e.yw = eyw; e.err = eerr; e.lp = elp;
        exp_q.push_back(e);
        @(negedge clk);
        load     = 1'b0;
        day_tick = 1'b0;
        day_dec  = 1'b0;
        pop_and_compare(tag);
    endtask

    initial begin
        exp_t r;
        rst_n    = 1'b0;
        day_tick = 1'b0;
        day_dec  = 1'b0;
        load     = 1'b0;
        set_date = 32'h0;
        set_wday = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //       tag        op       set_date      wd    exp_date      wd    mw    yw    err   leap
        step("reset",   OP_IDLE, 32'h0,        3'd0, 32'h20190101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld0228",  OP_LOAD, 32'h20200228, 3'd5, 32'h20200228, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        step("tk0229",  OP_TICK, 32'h0,        3'd0, 32'h20200229, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        step("tk0301",  OP_TICK, 32'h0,        3'd0, 32'h20200301, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("mwdrop",  OP_IDLE, 32'h0,        3'd0, 32'h20200301, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ld2100",  OP_LOAD, 32'h21000228, 3'd0, 32'h21000228, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("tk2100",  OP_TICK, 32'h0,        3'd0, 32'h21000301, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld2000",  OP_LOAD, 32'h20000228, 3'd1, 32'h20000228, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("tk2000",  OP_TICK, 32'h0,        3'd0, 32'h20000229, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        step("ld2099",  OP_LOAD, 32'h20991231, 3'd4, 32'h20991231, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step("tkyear",  OP_TICK, 32'h0,        3'd0, 32'h21000101, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step("ywdrop",  OP_IDLE, 32'h0,        3'd0, 32'h21000101, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld9999",  OP_LOAD, 32'h99991231, 3'd3, 32'h99991231, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step("tk0000",  OP_TICK, 32'h0,        3'd0, 32'h00000101, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        step("ld0301",  OP_LOAD, 32'h20200301, 3'd0, 32'h20200301, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("dc0229",  OP_DEC,  32'h0,        3'd0, 32'h20200229, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        step("ld0101",  OP_LOAD, 32'h20190101, 3'd2, 32'h20190101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("dc1231",  OP_DEC,  32'h0,        3'd0, 32'h20181231, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("both",    OP_BOTH, 32'h0,        3'd0, 32'h20181231, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("bad0229", OP_LOAD, 32'h20190229, 3'd5, 32'h20181231, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bad13",   OP_LOAD, 32'h20191301, 3'd0, 32'h20181231, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("bad0431", OP_LOAD, 32'h20190431, 3'd0, 32'h20181231, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("errhold", OP_TICK, 32'h0,        3'd0, 32'h20190101, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step("ok0430",  OP_LOAD, 32'h20190430, 3'd2, 32'h20190430, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ldtick",  OP_LDTK, 32'h20191231, 3'd2, 32'h20191231, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("badwday", OP_LOAD, 32'h20190101, 3'd7, 32'h20191231, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step("badnib",  OP_LOAD, 32'h201A0101, 3'd1, 32'h20191231, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step("ld0910",  OP_LOAD, 32'h20190910, 3'd2, 32'h20190910, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("dc0909",  OP_DEC,  32'h0,        3'd0, 32'h20190909, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("tk0910",  OP_TICK, 32'h0,        3'd0, 32'h20190910, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step("ld1031",  OP_LOAD, 32'h20191031, 3'd4, 32'h20191031, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step("tk1101",  OP_TICK, 32'h0,        3'd0, 32'h20191101, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld0301n", OP_LOAD, 32'h20190301, 3'd5, 32'h20190301, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step("dc0228",  OP_DEC,  32'h0,        3'd0, 32'h20190228, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld0000",  OP_LOAD, 32'h00000101, 3'd6, 32'h00000101, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        step("dc9999",  OP_DEC,  32'h0,        3'd0, 32'h99991231, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of activity overrides immediately.
        day_tick = 1'b1;
        rst_n    = 1'b0;
        r.date = 32'h20190101; r.wday = 3'd2; r.mw = 1'b0; r.yw = 1'b0; r.err = 1'b0; r.lp = 1'b0;
        exp_q.push_back(r);
        #1;
        pop_and_compare("midrst");
        @(negedge clk);
        day_tick = 1'b0;
        rst_n    = 1'b1;
        step("postrst", OP_IDLE, 32'h0,        3'd0, 32'h20190101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        check("q_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
